// File: rtl/apb_master_bridge.sv
// APB requester: one host command at a time, range check and wait-state timeout; response 3 cycles after accept (+1 per wait state, 1 for out-of-range).
// cmd_ready only in IDLE, so the host is held off while a transfer is in flight; rsp_valid cannot be backpressured.
module apb_master_bridge #(
    parameter int ADDRESS  = 8,
    parameter int DATA     = 8,
    parameter int LOCATION = 64,
    parameter int TIMEOUT  = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDRESS-1:0] cmd_addr,
    input  logic [DATA-1:0]    cmd_wdata,
    output logic               rsp_valid,
    output logic [DATA-1:0]    rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL1,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDRESS-1:0] paddr,
    output logic [DATA-1:0]    pwdata,
    input  logic               PREADY,
    input  logic [DATA-1:0]    prdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          in_range;

    assign cmd_ready = (state == IDLE) && !PRESET;
    assign in_range  = 32'(cmd_addr) < 32'(LOCATION);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PSEL1     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (in_range) begin
                            state   <= SETUP;
                            PSEL1   <= 1'b1;
                            PENABLE <= 1'b0;
                            paddr   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            pwdata  <= cmd_write ? cmd_wdata : '0;
                        end else begin
                            // rejected without touching the bus; APB outputs keep their last values
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state     <= IDLE;
                        PSEL1     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : prdata;
                    end else if (wait_cnt == TMO) begin
                        state     <= IDLE;
                        PSEL1     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with an in-bench APB RAM / wait-state stub slave.
module tb_apb_master_bridge;

    logic       PCLK;
    logic       PRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       PREADY;
    logic [7:0] prdata;

    int checks;
    int failures;

    // slave model controls
    logic       use_stub;
    logic       stuck;
    logic [7:0] waits;
    logic [7:0] acc_cyc;
    logic [7:0] mem [64] = '{default: 8'h00};

    apb_master_bridge #(
        .ADDRESS(8), .DATA(8), .LOCATION(64), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .paddr(paddr), .pwdata(pwdata), .PREADY(PREADY), .prdata(prdata)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign PREADY = PSEL1 && PENABLE && !stuck && (acc_cyc == waits);
    assign prdata = use_stub ? 8'h5C : mem[paddr[5:0]];

    always @(posedge PCLK) begin
        if (PSEL1 && PENABLE && !PREADY) acc_cyc <= acc_cyc + 8'd1;
        else                             acc_cyc <= 8'd0;
        if (PSEL1 && PENABLE && PREADY && PWRITE && !use_stub) mem[paddr[5:0]] <= pwdata;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // issue one command, then follow it to its response
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int cyc, output int n_set, output int n_acc,
                        output logic [7:0] rd, output logic er, output logic psel_rsp);
        int g;
        cyc = 0; n_set = 0; n_acc = 0; rd = 8'h00; er = 1'b0; psel_rsp = 1'b0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge PCLK);
            g++;
        end
        check_val("xfer_accept", cmd_ready, 1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 60) begin
            if (PSEL1 && !PENABLE) n_set++;
            if (PSEL1 && PENABLE)  n_acc++;
            @(negedge PCLK);
            cyc++;
        end
        check_val("rsp_seen", rsp_valid, 1);
        rd = rsp_rdata; er = rsp_err; psel_rsp = PSEL1;
        @(negedge PCLK);
        check_val("rsp_single_pulse", rsp_valid, 0);
    endtask

    initial begin
        int cyc, n_set, n_acc, idle, total, rsp_cnt, idx;
        logic [7:0] rd;
        logic er, ps, acc;
        logic [7:0] b2b_d [4];

        checks = 0; failures = 0;
        use_stub = 1'b0; stuck = 1'b0; waits = 8'd0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);

        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_psel", PSEL1, 0);
        check_val("rst_penable", PENABLE, 0);
        check_val("rst_pwrite", PWRITE, 0);
        check_val("rst_paddr", paddr, 0);
        check_val("rst_pwdata", pwdata, 0);
        check_val("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_val("idle_cmd_ready", cmd_ready, 1);

        // write then read back through the RAM slave
        xfer(1'b1, 8'h10, 8'hA5, cyc, n_set, n_acc, rd, er, ps);
        check_val("wr_latency", cyc, 3);
        check_val("wr_setup_cycles", n_set, 1);
        check_val("wr_access_cycles", n_acc, 1);
        check_val("wr_err", er, 0);
        check_val("wr_psel_at_rsp", ps, 0);
        check_val("wr_mem", mem[16], 8'hA5);
        xfer(1'b0, 8'h10, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("rd_latency", cyc, 3);
        check_val("rd_data", rd, 8'hA5);
        check_val("rd_err", er, 0);

        // back-to-back writes with cmd_valid held high
        b2b_d[0] = 8'h11; b2b_d[1] = 8'h22; b2b_d[2] = 8'h33; b2b_d[3] = 8'h44;
        idx = 0; idle = 0; total = 0; rsp_cnt = 0;
        cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = b2b_d[0]; cmd_valid = 1'b1;
        while (rsp_cnt < 4 && total < 60) begin
            acc = cmd_valid && cmd_ready;
            @(negedge PCLK);
            total++;
            if (!PSEL1) idle++;
            if (rsp_valid) begin
                rsp_cnt++;
                check_val("b2b_err", rsp_err, 0);
            end
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    cmd_addr = 8'(idx);
                    cmd_wdata = b2b_d[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check_val("b2b_rsp_count", rsp_cnt, 4);
        check_val("b2b_total_cycles", total, 12);
        check_val("b2b_idle_cycles", idle, 4);
        @(negedge PCLK);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'(i), 8'h00, cyc, n_set, n_acc, rd, er, ps);
            check_val($sformatf("b2b_rd%0d", i), rd, b2b_d[i]);
        end

        // out-of-range
        xfer(1'b0, 8'h10, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        xfer(1'b0, 8'h40, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("oor_latency", cyc, 1);
        check_val("oor_no_psel", n_set + n_acc, 0);
        check_val("oor_err", er, 1);
        check_val("oor_rdata", rd, 0);

        // three wait states
        use_stub = 1'b1; waits = 8'd3;
        xfer(1'b0, 8'h05, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("ws3_access_cycles", n_acc, 4);
        check_val("ws3_latency", cyc, 6);
        check_val("ws3_rdata", rd, 8'h5C);
        check_val("ws3_err", er, 0);

        // slave never ready
        stuck = 1'b1;
        xfer(1'b0, 8'h05, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("tmo_access_cycles", n_acc, 17);
        check_val("tmo_latency", cyc, 19);
        check_val("tmo_err", er, 1);
        check_val("tmo_rdata", rd, 0);
        check_val("tmo_psel_at_rsp", ps, 0);
        stuck = 1'b0; use_stub = 1'b0; waits = 8'd0;
        xfer(1'b0, 8'h10, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("post_tmo_rdata", rd, 8'hA5);
        check_val("post_tmo_err", er, 0);

        // reset during ACCESS of a write
        cmd_write = 1'b1; cmd_addr = 8'h08; cmd_wdata = 8'h77; cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check_val("abort_setup_psel", {PSEL1, PENABLE}, 2'b10);
        @(negedge PCLK);
        check_val("abort_access", {PSEL1, PENABLE, PWRITE}, 3'b111);
        #1 PRESET = 1'b1;
        #1;
        check_val("abort_psel", {PSEL1, PENABLE}, 0);
        check_val("abort_pwrite", PWRITE, 0);
        check_val("abort_paddr", paddr, 0);
        check_val("abort_pwdata", pwdata, 0);
        check_val("abort_cmd_ready", cmd_ready, 0);
        @(negedge PCLK);
        check_val("abort_no_rsp", rsp_valid, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        xfer(1'b0, 8'h08, 8'h00, cyc, n_set, n_acc, rd, er, ps);
        check_val("abort_rd_data", rd, 8'h00);
        check_val("abort_rd_err", er, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
